muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with fixed-latency MULT/MADD/DIV and single-edge MTHI/MTLO.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_is_div;
  logic               w_mul_signed;
  logic               w_is_madd;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_uquo;
  logic [WIDTH-1:0]   w_urem;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Result datapath works only from operands latched at the accepting edge.
  always_comb begin
    w_is_div     = (r_op == OP_DIV) || (r_op == OP_DIVU);
    w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD);
    w_is_madd    = (r_op == OP_MADD) || (r_op == OP_MADDU);
    w_a_ext      = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_b_ext      = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod       = w_a_ext * w_b_ext;
    w_mul_res    = w_is_madd ? (r_acc + w_prod) : w_prod;
  end

  // Signed divide via magnitudes; most-negative / -1 falls out as lo=most-negative, hi=0.
  always_comb begin
    w_div_signed = (r_op == OP_DIV);
    w_a_neg      = w_div_signed && r_a[WIDTH-1];
    w_b_neg      = w_div_signed && r_b[WIDTH-1];
    w_abs_a      = w_a_neg ? -r_a : r_a;
    w_abs_b      = w_b_neg ? -r_b : r_b;
    w_uquo       = '0;
    w_urem       = '0;
    if (r_b != '0) begin
      w_uquo = w_abs_a / w_abs_b;
      w_urem = w_abs_a % w_abs_b;
    end
    w_quo = (w_a_neg ^ w_b_neg) ? -w_uquo : w_uquo;
    w_rem = w_a_neg ? -w_urem : w_urem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: begin
                r_op    <= op;
                r_a     <= a;
                r_b     <= b;
                r_acc   <= {r_hi, r_lo};
                r_state <= RUN;
                if ((op == OP_DIV) || (op == OP_DIVU))
                  r_cnt <= CNT_W'(DIV_LAT - 1);
                else
                  r_cnt <= CNT_W'(MUL_LAT - 1);
              end
            endcase
          end
        end
        default: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            if (!w_is_div) begin
              {r_hi, r_lo} <= w_mul_res;
            end else if (r_b != '0) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'd0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0);
    chk("reset_hi", hi, 0); chk("reset_lo", lo, 0);

    // MULT -2 * 3
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("mult_busy", busy, 1); chk("mult_done_early", done, 0);
      tick();
    end
    chk("mult_busy_last", busy, 1);
    tick();
    chk("mult_busy_fall", busy, 0); chk("mult_done", done, 1);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);
    tick();
    chk("mult_done_once", done, 0);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    for (int i = 0; i < 9; i++) begin
      chk("div_busy", busy, 1); chk("div_done_early", done, 0);
      tick();
    end
    chk("div_busy_last", busy, 1);
    tick();
    chk("div_done", done, 1); chk("div_busy_fall", busy, 0);
    chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF);
    tick();

    // DIVU 7 / 0 leaves HI/LO alone
    issue(3'd3, 32'd7, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    chk("divz_busy_last", busy, 1);
    tick();
    chk("divz_done", done, 1); chk("divz_hi", hi, 32'hFFFFFFFF); chk("divz_lo", lo, 32'hFFFFFFFD);
    tick();

    // most-negative / -1
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) tick();
    chk("ovf_done", done, 1); chk("ovf_lo", lo, 32'h80000000); chk("ovf_hi", hi, 32'h0);

    // MTHI / MTLO then MADDU
    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi", hi, 32'h12345678); chk("mthi_busy", busy, 0); chk("mthi_done", done, 0);
    issue(3'd5, 32'd0, 32'd0);
    chk("mtlo_lo", lo, 32'd0); chk("mtlo_busy", busy, 0);
    issue(3'd7, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    chk("maddu_busy_last", busy, 1);
    tick();
    chk("maddu_done", done, 1); chk("maddu_hi", hi, 32'h12345679); chk("maddu_lo", lo, 32'hFFFFFFFE);

    // MADD signed -1 * 2 accumulates -2
    issue(3'd6, 32'hFFFFFFFF, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("madd_done", done, 1); chk("madd_hi", hi, 32'h12345679); chk("madd_lo", lo, 32'hFFFFFFFC);
    tick();

    // flush in cycle 3 of MULT, with an ignored start while busy
    issue(3'd0, 32'd3, 32'd4);
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    chk("busy_start_ign_hi", hi, 32'h12345679); chk("busy_start_busy", busy, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0); chk("flush_done", done, 0);
    chk("flush_hi", hi, 32'h12345679); chk("flush_lo", lo, 32'hFFFFFFFC);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_done", done, 0); chk("flush_idle", busy, 0);
    end

    // flush coinciding with completion edge
    issue(3'd0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_end_busy", busy, 0); chk("flush_end_done", done, 0);
    chk("flush_end_hi", hi, 32'h12345679); chk("flush_end_lo", lo, 32'hFFFFFFFC);
    tick();
    chk("flush_end_done2", done, 0);

    // start with flush in IDLE is ignored
    flush = 1'b1;
    issue(3'd4, 32'h77, 32'd0);
    flush = 1'b0;
    chk("flush_idle_start_hi", hi, 32'h12345679);

    // reset mid-DIV
    issue(3'd2, 32'd100, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_hi", hi, 0); chk("rst_mid_lo", lo, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_mid_no_done", done, 0);
    end

    // reset beats start
    reset = 1'b1;
    issue(3'd4, 32'h55, 32'd0);
    reset = 1'b0;
    chk("rst_prio_hi", hi, 0);

    // back-to-back MULTU then MTLO
    issue(3'd1, 32'h00010000, 32'h00010000);
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("b2b_busy_fall", busy, 0); chk("b2b_done", done, 1);
    issue(3'd5, 32'd5, 32'd0);
    chk("b2b_hi", hi, 32'd1); chk("b2b_lo", lo, 32'd5);
    chk("b2b_busy", busy, 0); chk("b2b_done_gone", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
